// File: rtl/sa_ram_arb_pkg.sv
// Shared definitions for the 80x256 RAM read-arbitration front end.
// Holds the geometry defaults, client-id encoding and the pipeline stage record.
package sa_ram_arb_pkg;

  localparam int unsigned DEPTH = 80;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 256;

  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_e;

  // One read in flight: valid, owning client, out-of-range flag
  typedef struct packed {
    logic    vld;
    client_e own;
    logic    oor;
  } stage_t;

  function automatic logic addr_oor(input logic [AW-1:0] addr);
    return addr >= AW'(DEPTH);
  endfunction

endpackage

// File: rtl/sa_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: clk/rst_n, en (arbitrate this cycle), req[1:0],
//        gnt_c[1:0] (one-hot grant, combinational), gnt_id_c (granted client).
// The priority pointer moves to the other client only when a grant is issued.
module sa_rr_arb2
  import sa_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c,
  output client_e    gnt_id_c
);

  client_e prio_q;
  client_e prio_d;

  // Grant selection and next pointer
  always_comb begin
    gnt_c  = 2'b00;
    prio_d = prio_q;
    if (en) begin
      if (req == 2'b11) begin
        gnt_c = (prio_q == CLIENT1) ? 2'b10 : 2'b01;
      end else begin
        gnt_c = req;
      end
    end
    gnt_id_c = gnt_c[1] ? CLIENT1 : CLIENT0;
    if (gnt_c != 2'b00) begin
      prio_d = gnt_c[1] ? CLIENT0 : CLIENT1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= CLIENT0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/sa_ram_rwsp_rd_arb.sv
// Front-end controller for the 80x256 two-port RAM macro.
// Read side: two clients share the read port via round-robin; the 2-stage
// macro read pipeline (re -> address reg, ore -> output reg) is sequenced
// with full backpressure for one read per cycle.
// Write side: single writer passed straight through; out-of-range dropped.
// Ports: rdN_req_* (request), rdN_rsp_* (response), rd_rsp_pd (shared data),
//        wr_req_* (write), ram_* (macro controls), ram_dout (macro output).
module sa_ram_rwsp_rd_arb
  import sa_ram_arb_pkg::*;
(
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          rd0_req_pvld,
  output logic          rd0_req_prdy,
  input  logic [AW-1:0] rd0_req_addr,
  input  logic          rd1_req_pvld,
  output logic          rd1_req_prdy,
  input  logic [AW-1:0] rd1_req_addr,
  output logic          rd0_rsp_pvld,
  input  logic          rd0_rsp_prdy,
  output logic          rd1_rsp_pvld,
  input  logic          rd1_rsp_prdy,
  output logic [DW-1:0] rd_rsp_pd,
  input  logic          wr_req_pvld,
  output logic          wr_req_prdy,
  input  logic [AW-1:0] wr_req_addr,
  input  logic [DW-1:0] wr_req_data,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  output logic          ram_ore,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_dout
);

  stage_t        s1_q, s1_d;
  stage_t        s2_q, s2_d;
  logic          rsp_acc;
  logic          s1_adv;
  logic          s0_go;
  logic [1:0]    gnt;
  client_e       gnt_id;
  logic          gnt_vld;
  logic          gnt_oor;
  logic [AW-1:0] gnt_addr;

  // Stage advance: a stage moves only when the stage after it is free
  always_comb begin
    rsp_acc = s2_q.vld & ((s2_q.own == CLIENT1) ? rd1_rsp_prdy : rd0_rsp_prdy);
    s1_adv  = ~s2_q.vld | rsp_acc;
    s0_go   = ~s1_q.vld | s1_adv;
  end

  sa_rr_arb2 u_arb (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .en       (s0_go),
    .req      ({rd1_req_pvld, rd0_req_pvld}),
    .gnt_c    (gnt),
    .gnt_id_c (gnt_id)
  );

  // S0 grant, RAM read controls and next stage contents
  always_comb begin
    gnt_vld  = |gnt;
    gnt_addr = gnt[1] ? rd1_req_addr : rd0_req_addr;
    gnt_oor  = addr_oor(gnt_addr);

    rd0_req_prdy = gnt[0];
    rd1_req_prdy = gnt[1];

    // Out-of-range reads skip the macro access but still occupy a slot
    ram_re  = gnt_vld & ~gnt_oor;
    ram_ra  = gnt_vld ? gnt_addr : '0;
    // Stalled: ore stays low so the macro output register holds the data
    ram_ore = s1_q.vld & s1_adv;

    s1_d = s1_q;
    if (s0_go) begin
      s1_d.vld = gnt_vld;
      s1_d.own = gnt_id;
      s1_d.oor = gnt_vld & gnt_oor;
    end
    s2_d = s1_adv ? s1_q : s2_q;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // S2 response routing
  always_comb begin
    rd0_rsp_pvld = s2_q.vld & (s2_q.own == CLIENT0);
    rd1_rsp_pvld = s2_q.vld & (s2_q.own == CLIENT1);
    rd_rsp_pd    = s2_q.oor ? '0 : ram_dout;
  end

  // Write pass-through
  always_comb begin
    wr_req_prdy = 1'b1;
    ram_we      = wr_req_pvld & ~addr_oor(wr_req_addr);
    ram_wa      = wr_req_addr;
    ram_di      = wr_req_data;
  end

endmodule

// File: tb/tb_sa_ram_rwsp_rd_arb.sv
// Bench for sa_ram_rwsp_rd_arb: vector table, directed corner sequences and
// a randomized run against a transaction-level reference model.
module tb_sa_ram_rwsp_rd_arb;
  import sa_ram_arb_pkg::*;

  logic          nvdla_core_clk = 1'b0;
  logic          nvdla_core_rstn;
  logic          rd0_req_pvld, rd0_req_prdy, rd1_req_pvld, rd1_req_prdy;
  logic [AW-1:0] rd0_req_addr, rd1_req_addr;
  logic          rd0_rsp_pvld, rd0_rsp_prdy, rd1_rsp_pvld, rd1_rsp_prdy;
  logic [DW-1:0] rd_rsp_pd;
  logic          wr_req_pvld, wr_req_prdy;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          ram_re, ram_ore, ram_we;
  logic [AW-1:0] ram_ra, ram_wa;
  logic [DW-1:0] ram_di, ram_dout;

  sa_ram_rwsp_rd_arb dut (
    .nvdla_core_clk (nvdla_core_clk), .nvdla_core_rstn (nvdla_core_rstn),
    .rd0_req_pvld (rd0_req_pvld), .rd0_req_prdy (rd0_req_prdy), .rd0_req_addr (rd0_req_addr),
    .rd1_req_pvld (rd1_req_pvld), .rd1_req_prdy (rd1_req_prdy), .rd1_req_addr (rd1_req_addr),
    .rd0_rsp_pvld (rd0_rsp_pvld), .rd0_rsp_prdy (rd0_rsp_prdy),
    .rd1_rsp_pvld (rd1_rsp_pvld), .rd1_rsp_prdy (rd1_rsp_prdy),
    .rd_rsp_pd (rd_rsp_pd),
    .wr_req_pvld (wr_req_pvld), .wr_req_prdy (wr_req_prdy),
    .wr_req_addr (wr_req_addr), .wr_req_data (wr_req_data),
    .ram_re (ram_re), .ram_ra (ram_ra), .ram_ore (ram_ore),
    .ram_we (ram_we), .ram_wa (ram_wa), .ram_di (ram_di),
    .ram_dout (ram_dout)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  // Macro model: registered read address, registered output
  logic [DW-1:0] mem [0:127];
  logic [AW-1:0] ra_d;
  logic [DW-1:0] dout_r;
  always @(posedge nvdla_core_clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_d <= ram_ra;
    if (ram_ore) dout_r <= mem[ra_d];
  end
  assign ram_dout = dout_r;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] golden [DEPTH];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic cyc();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic idle();
    rd0_req_pvld = 1'b0; rd1_req_pvld = 1'b0;
    rd0_req_addr = '0;   rd1_req_addr = '0;
    rd0_rsp_prdy = 1'b1; rd1_rsp_prdy = 1'b1;
    wr_req_pvld  = 1'b0; wr_req_addr  = '0; wr_req_data = '0;
  endtask

  task automatic do_reset();
    idle();
    nvdla_core_rstn = 1'b0;
    repeat (2) @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;
  endtask

  typedef struct {
    logic r0, r1; logic [AW-1:0] a0, a1; logic w; logic [AW-1:0] wa;
    logic p0, p1, re; logic [AW-1:0] ra; logic ore, we, v0, v1;
  } vec_t;
  vec_t tbl [10];

  typedef struct {
    logic own; logic [AW-1:0] addr; int cnum;
  } txn_t;
  txn_t q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] x1;
    logic          last, win, front_rdy, rsp_acc, exp_acc;
    logic [AW-1:0] waddr;
    int            cnum;

    //                r0 r1  a0  a1  w  wa   p0 p1 re  ra  ore we v0 v1
    tbl[0] = '{1'b0,1'b0, 7'd0, 7'd0, 1'b1,7'd3,  1'b0,1'b0,1'b0,7'd0, 1'b0,1'b1,1'b0,1'b0};
    tbl[1] = '{1'b1,1'b0, 7'd5, 7'd0, 1'b1,7'd85, 1'b1,1'b0,1'b1,7'd5, 1'b0,1'b0,1'b0,1'b0};
    tbl[2] = '{1'b1,1'b1, 7'd7, 7'd9, 1'b0,7'd0,  1'b0,1'b1,1'b1,7'd9, 1'b1,1'b0,1'b0,1'b0};
    tbl[3] = '{1'b1,1'b1, 7'd12,7'd90,1'b0,7'd0,  1'b1,1'b0,1'b1,7'd12,1'b1,1'b0,1'b1,1'b0};
    tbl[4] = '{1'b1,1'b1, 7'd12,7'd90,1'b0,7'd0,  1'b0,1'b1,1'b0,7'd90,1'b1,1'b0,1'b0,1'b1};
    tbl[5] = '{1'b0,1'b1, 7'd0, 7'd79,1'b0,7'd0,  1'b0,1'b1,1'b1,7'd79,1'b1,1'b0,1'b1,1'b0};
    tbl[6] = '{1'b0,1'b1, 7'd0, 7'd80,1'b0,7'd0,  1'b0,1'b1,1'b0,7'd80,1'b1,1'b0,1'b0,1'b1};
    tbl[7] = '{1'b1,1'b1, 7'd0, 7'd1, 1'b0,7'd0,  1'b1,1'b0,1'b1,7'd0, 1'b1,1'b0,1'b0,1'b1};
    tbl[8] = '{1'b0,1'b0, 7'd0, 7'd0, 1'b1,7'd79, 1'b0,1'b0,1'b0,7'd0, 1'b1,1'b1,1'b0,1'b1};
    tbl[9] = '{1'b0,1'b0, 7'd0, 7'd0, 1'b1,7'd80, 1'b0,1'b0,1'b0,7'd0, 1'b0,1'b0,1'b1,1'b0};

    // Reset state
    idle();
    nvdla_core_rstn = 1'b0;
    #3;
    chk("rst_v0", DW'(rd0_rsp_pvld), DW'(0));
    chk("rst_v1", DW'(rd1_rsp_pvld), DW'(0));
    chk("rst_ore", DW'(ram_ore), DW'(0));
    chk("rst_re", DW'(ram_re), DW'(0));
    chk("rst_we", DW'(ram_we), DW'(0));
    chk("rst_wrdy", DW'(wr_req_prdy), DW'(1));
    do_reset();

    // Vector table, one row per cycle
    for (int i = 0; i < 10; i++) begin
      rd0_req_pvld = tbl[i].r0; rd1_req_pvld = tbl[i].r1;
      rd0_req_addr = tbl[i].a0; rd1_req_addr = tbl[i].a1;
      wr_req_pvld  = tbl[i].w;  wr_req_addr  = tbl[i].wa;
      wr_req_data  = pat(int'(tbl[i].wa));
      #2;
      chk($sformatf("tbl%0d_p0", i), DW'(rd0_req_prdy), DW'(tbl[i].p0));
      chk($sformatf("tbl%0d_p1", i), DW'(rd1_req_prdy), DW'(tbl[i].p1));
      chk($sformatf("tbl%0d_re", i), DW'(ram_re), DW'(tbl[i].re));
      if (tbl[i].p0 || tbl[i].p1) chk($sformatf("tbl%0d_ra", i), DW'(ram_ra), DW'(tbl[i].ra));
      chk($sformatf("tbl%0d_ore", i), DW'(ram_ore), DW'(tbl[i].ore));
      chk($sformatf("tbl%0d_we", i), DW'(ram_we), DW'(tbl[i].we));
      chk($sformatf("tbl%0d_v0", i), DW'(rd0_rsp_pvld), DW'(tbl[i].v0));
      chk($sformatf("tbl%0d_v1", i), DW'(rd1_rsp_pvld), DW'(tbl[i].v1));
      cyc();
    end
    idle();

    // Preload every entry through the write port
    for (int i = 0; i < int'(DEPTH); i++) begin
      wr_req_pvld = 1'b1; wr_req_addr = AW'(i); wr_req_data = pat(i);
      golden[i] = pat(i);
      cyc();
    end
    idle();

    // Single read of addr 5
    wr_req_pvld = 1'b1; wr_req_addr = 7'd5; wr_req_data = {32{8'hA5}};
    golden[5] = {32{8'hA5}};
    cyc();
    idle();
    rd0_req_pvld = 1'b1; rd0_req_addr = 7'd5;
    #2;
    chk("sr_prdy", DW'(rd0_req_prdy), DW'(1));
    chk("sr_re", DW'(ram_re), DW'(1));
    chk("sr_ra", DW'(ram_ra), DW'(5));
    cyc();
    rd0_req_pvld = 1'b0;
    #2;
    chk("sr_re_off", DW'(ram_re), DW'(0));
    chk("sr_ore", DW'(ram_ore), DW'(1));
    chk("sr_early", DW'(rd0_rsp_pvld), DW'(0));
    cyc();
    #2;
    chk("sr_v0", DW'(rd0_rsp_pvld), DW'(1));
    chk("sr_pd", rd_rsp_pd, {32{8'hA5}});
    chk("sr_ore_off", DW'(ram_ore), DW'(0));
    cyc();
    #2;
    chk("sr_v0_off", DW'(rd0_rsp_pvld), DW'(0));
    cyc();

    // Out-of-range read and write
    rd0_req_pvld = 1'b1; rd0_req_addr = 7'd90;
    wr_req_pvld = 1'b1; wr_req_addr = 7'd85; wr_req_data = '1;
    #2;
    chk("oor_prdy", DW'(rd0_req_prdy), DW'(1));
    chk("oor_re", DW'(ram_re), DW'(0));
    chk("oor_we", DW'(ram_we), DW'(0));
    cyc();
    idle();
    cyc();
    #2;
    chk("oor_v0", DW'(rd0_rsp_pvld), DW'(1));
    chk("oor_pd", rd_rsp_pd, DW'(0));
    cyc();

    // Same-cycle write and read of addr 10 returns the new data
    x1 = {8{32'h1111_2222}};
    wr_req_pvld = 1'b1; wr_req_addr = 7'd10; wr_req_data = x1;
    rd1_req_pvld = 1'b1; rd1_req_addr = 7'd10;
    golden[10] = x1;
    #2;
    chk("hz_prdy", DW'(rd1_req_prdy), DW'(1));
    chk("hz_we", DW'(ram_we), DW'(1));
    cyc();
    idle();
    cyc();
    #2;
    chk("hz_v1", DW'(rd1_rsp_pvld), DW'(1));
    chk("hz_pd", rd_rsp_pd, x1);
    cyc();

    // Backpressure: client 0 stalls its response for 4 cycles
    for (int k = 0; k < 10; k++) begin
      rd0_req_pvld = (k <= 6);
      rd0_req_addr = (k < 2) ? AW'(40 + k) : 7'd42;
      rd0_rsp_prdy = !(k >= 2 && k <= 5);
      #2;
      if (k >= 2 && k <= 5) begin
        chk($sformatf("bp%0d_v0", k), DW'(rd0_rsp_pvld), DW'(1));
        chk($sformatf("bp%0d_pd", k), rd_rsp_pd, pat(40));
        chk($sformatf("bp%0d_re", k), DW'(ram_re), DW'(0));
        chk($sformatf("bp%0d_ore", k), DW'(ram_ore), DW'(0));
        chk($sformatf("bp%0d_prdy", k), DW'(rd0_req_prdy), DW'(0));
      end
      if (k == 6) begin
        chk("bp_rel_prdy", DW'(rd0_req_prdy), DW'(1));
        chk("bp_rel_ore", DW'(ram_ore), DW'(1));
      end
      if (k == 7 || k == 8) begin
        chk($sformatf("bp%0d_v0", k), DW'(rd0_rsp_pvld), DW'(1));
        chk($sformatf("bp%0d_pd", k), rd_rsp_pd, pat(34 + k));
      end
      if (k == 9) chk("bp_tail", DW'(rd0_rsp_pvld), DW'(0));
      cyc();
    end
    idle();

    // Contention after reset: grants alternate starting with client 0
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rd0_req_pvld = (k < 6); rd1_req_pvld = (k < 6);
      rd0_req_addr = 7'd20;   rd1_req_addr = 7'd30;
      #2;
      if (k < 6) begin
        chk($sformatf("ct%0d_p0", k), DW'(rd0_req_prdy), DW'(k % 2 == 0));
        chk($sformatf("ct%0d_p1", k), DW'(rd1_req_prdy), DW'(k % 2 == 1));
      end
      if (k >= 2) begin
        chk($sformatf("ct%0d_v0", k), DW'(rd0_rsp_pvld), DW'(k % 2 == 0));
        chk($sformatf("ct%0d_v1", k), DW'(rd1_rsp_pvld), DW'(k % 2 == 1));
        chk($sformatf("ct%0d_pd", k), rd_rsp_pd, (k % 2 == 1) ? pat(30) : pat(20));
      end
      cyc();
    end
    idle();
    cyc();

    // Reset with s1 and s2 both occupied
    do_reset();
    rd0_req_pvld = 1'b1; rd1_req_pvld = 1'b1;
    rd0_req_addr = 7'd20; rd1_req_addr = 7'd30;
    cyc();
    cyc();
    #1;
    nvdla_core_rstn = 1'b0;
    #1;
    chk("mr_v0", DW'(rd0_rsp_pvld), DW'(0));
    chk("mr_v1", DW'(rd1_rsp_pvld), DW'(0));
    chk("mr_ore", DW'(ram_ore), DW'(0));
    idle();
    repeat (2) @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("mr_quiet%0d", k), DW'(rd0_rsp_pvld | rd1_rsp_pvld), DW'(0));
      cyc();
    end
    rd0_req_pvld = 1'b1; rd1_req_pvld = 1'b1;
    #2;
    chk("mr_p0", DW'(rd0_req_prdy), DW'(1));
    chk("mr_p1", DW'(rd1_req_prdy), DW'(0));
    cyc();
    idle();
    repeat (3) cyc();

    // Randomized run against a transaction-level model (no writes)
    do_reset();
    q.delete();
    last = 1'b1;
    cnum = 0;
    for (int i = 0; i < 406; i++) begin
      if (i < 400) begin
        rd0_req_pvld = ($urandom_range(0, 3) != 0);
        rd1_req_pvld = ($urandom_range(0, 3) != 0);
        rd0_req_addr = AW'($urandom_range(0, 95));
        rd1_req_addr = AW'($urandom_range(0, 95));
        rd0_rsp_prdy = ($urandom_range(0, 3) != 0);
        rd1_rsp_prdy = ($urandom_range(0, 3) != 0);
      end else begin
        idle();
      end
      #2;
      // Oldest read is presented two cycles after its grant and waits there
      front_rdy = (q.size() > 0) && (cnum - q[0].cnum >= 2);
      chk($sformatf("rn%0d_v0", i), DW'(rd0_rsp_pvld), DW'(front_rdy && q[0].own == 1'b0));
      chk($sformatf("rn%0d_v1", i), DW'(rd1_rsp_pvld), DW'(front_rdy && q[0].own == 1'b1));
      if (front_rdy)
        chk($sformatf("rn%0d_pd", i), rd_rsp_pd,
            (q[0].addr < AW'(DEPTH)) ? golden[q[0].addr] : DW'(0));
      rsp_acc = front_rdy && (q[0].own ? rd1_rsp_prdy : rd0_rsp_prdy);
      // At most two reads outstanding; a slot frees when a response is taken
      exp_acc = (rd0_req_pvld || rd1_req_pvld) && (q.size() < 2 || rsp_acc);
      win = (rd0_req_pvld && rd1_req_pvld) ? ~last : rd1_req_pvld;
      chk($sformatf("rn%0d_p0", i), DW'(rd0_req_prdy), DW'(exp_acc && !win));
      chk($sformatf("rn%0d_p1", i), DW'(rd1_req_prdy), DW'(exp_acc && win));
      waddr = win ? rd1_req_addr : rd0_req_addr;
      chk($sformatf("rn%0d_re", i), DW'(ram_re), DW'(exp_acc && waddr < AW'(DEPTH)));
      if (exp_acc && waddr < AW'(DEPTH))
        chk($sformatf("rn%0d_ra", i), DW'(ram_ra), DW'(waddr));
      if (rsp_acc) void'(q.pop_front());
      if (exp_acc) begin
        txn_t t;
        t.own = win; t.addr = waddr; t.cnum = cnum;
        q.push_back(t);
        last = win;
      end
      cnum++;
      cyc();
    end
    chk("rn_drain", DW'(q.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_ram_rwsp_rd_arb.md
Name: sa_ram_rwsp_rd_arb

Overview:
- Front-end controller for the 80x256 two-port RAM macro (1 write port; read port with address register `re` and output register `ore`).
- Shares the read port between two requesters using round-robin arbitration.
- Sequences the 2-stage read pipeline with full backpressure, so throughput is 1 read per cycle.
- Passes a single write requester straight through to the RAM write port.
- Sits between two consumer engines and one producer in the systolic array buffer.

Parameters:
- DEPTH, 80, number of RAM entries.
- AW, 7, address width.
- DW, 256, data width.

Ports:
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- rd0_req_pvld  in  1  client 0 read request valid.
- rd0_req_prdy  out  1  client 0 request accepted.
- rd0_req_addr  in  AW  client 0 read address.
- rd1_req_pvld / rd1_req_prdy / rd1_req_addr  same as client 0, for client 1.
- rd0_rsp_pvld  out  1  response valid for client 0.
- rd0_rsp_prdy  in  1  client 0 accepts the response.
- rd1_rsp_pvld / rd1_rsp_prdy  same as client 0, for client 1.
- rd_rsp_pd  out  DW  response data, shared by both clients.
- wr_req_pvld  in  1  write valid.
- wr_req_prdy  out  1  write ready; constant 1.
- wr_req_addr  in  AW  write address.
- wr_req_data  in  DW  write data.
- ram_re, ram_ra[AW], ram_ore  out  RAM read controls.
- ram_we, ram_wa[AW], ram_di[DW]  out  RAM write controls.
- ram_dout  in  DW  RAM registered output.

Behaviour:
- Reset values:
  - all pvld outputs, ram_re, ram_ore, ram_we = 0.
  - ram_ra = 0.
  - round-robin pointer = client 0.
  - stage valids s1_vld, s2_vld = 0; owner/oor flags = 0.
- Pipeline:
  - S0 grant: ram_re = 1 and ram_ra = granted address. At the clock edge, s1_vld is set and s1_own / s1_oor are latched.
  - S1: ram_ore = s1_vld & s1_adv. At the edge, s1 moves into s2.
  - S2: rdN_rsp_pvld = s2_vld & (s2_own == N).
  - rd_rsp_pd = s2_oor ? 0 : ram_dout.
  - Latency from request acceptance to rsp_pvld is 2 cycles when there is no stall.
- Advance rules:
  - s2_free = ~s2_vld | rsp accepted this cycle.
  - s1_adv = s2_free.
  - s0_go = ~s1_vld | s1_adv.
  - When stalled, ram_re = 0 and ram_ore = 0, so ra_d and dout_r in the RAM hold. This keeps rd_rsp_pd stable while pvld is high.
- Arbitration:
  - Applies only when s0_go.
  - If both clients request, the client that was not granted last wins; the pointer updates only on a grant.
  - A single requester wins immediately.
  - rdN_req_prdy = s0_go & grant[N]. prdy does not depend combinationally on the client's own pvld beyond the arbitration.
- Out-of-range reads (addr >= DEPTH):
  - accepted normally, but ram_re is suppressed and s1_oor = 1.
  - the response still arrives in order with data = 0.
  - ram_ore is still pulsed on advance, which is harmless.
- Writes:
  - ram_we = wr_req_pvld & (wr_req_addr < DEPTH), combinational; ram_wa and ram_di are direct.
  - Out-of-range writes are dropped silently.
- Same-cycle write and read grant to the same address: the read returns the NEW data, inherent to macro timing. This is required and must not be masked.
- Response-valid hold rule: once rsp_pvld is high it stays high with constant data until prdy. No response reordering.
- Asynchronous reset mid-operation: in-flight reads are discarded, no response is produced, and the pointer returns to client 0.

Decomposition:
- Shared package sa_ram_arb_pkg:
  - DEPTH/AW/DW defaults.
  - client-id encoding (CLIENT0 = 0, CLIENT1 = 1).
  - stage record: vld, own, oor.
- One sub-module, sa_rr_arb2: 2-way round-robin arbiter with an enable input and a pointer update on grant.

Test Plan:
- Single read: write addr 5 = 0xA5..A5; rd0 reads 5 with rsp_prdy = 1 -> rd0_rsp_pvld exactly 2 cycles after acceptance, data 0xA5..A5; ram_re pulses once, then ram_ore once.
- Contention: both clients request continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; 1 response per cycle; each response routed to its owner.
- Backpressure: rd0_rsp_prdy = 0 for 4 cycles with a stream in flight -> rsp_pvld and rd_rsp_pd held constant, ram_re = ram_ore = 0 during the stall, no requests accepted; on release, no loss or duplication.
- Hazard: write addr 10 = X1 and rd1 read addr 10 in the same cycle (old value X0) -> response = X1.
- Out-of-range: read addr 90 -> response data 0, ram_re stays low that cycle; write addr 85 -> ram_we = 0, RAM contents unchanged.
- Reset mid-stream: assert nvdla_core_rstn low with s1 and s2 both valid -> all pvld = 0 immediately; after release, the first contention grant goes to client 0.
